// File: rtl/seg_scan_monitor.sv
// seg_scan_monitor: selects one of NCH 32-bit debug channels and scans it onto a
// common-anode seven-segment array. Optional leading-zero blanking: `define SEG_LZB_EN.
module seg_scan_monitor #(
  parameter int NCH        = 16,
  parameter int DIGITS     = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int AUTO_TICKS = 50000000,
  localparam int CW        = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NCH*32-1:0] ch_data,
  input  logic [CW-1:0]     sel,
  input  logic              auto_en,
  input  logic              step,
  output logic [DIGITS-1:0] sel_seg,
  output logic [6:0]        seg7,
  output logic [CW-1:0]     cur_ch
);

  localparam int DW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int AUTO_W = $clog2(AUTO_TICKS);

  localparam logic [DW-1:0]     LAST_DIG  = DW'(DIGITS - 1);
  localparam logic [CW-1:0]     LAST_CH   = CW'(NCH - 1);
  localparam logic [DIV_W-1:0]  LAST_DIV  = DIV_W'(SCAN_DIV - 1);
  localparam logic [AUTO_W-1:0] LAST_AUTO = AUTO_W'(AUTO_TICKS - 1);

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      4'hF:    pat = 7'h0E;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  // dig_idx_r holds the digit that the next scan tick will light, so the first
  // tick after reset lights digit 0 and the tick lighting the last digit closes a frame.
  logic [DIV_W-1:0]  div_cnt_r;
  logic [DW-1:0]     dig_idx_r;
  logic [AUTO_W-1:0] auto_cnt_r;
  logic [CW-1:0]     cur_ch_r;
  logic [31:0]       snap_r;
  logic              step_q_r;
  logic [DIGITS-1:0] sel_seg_r;
  logic [6:0]        seg7_r;

  logic              scan_tick_s;
  logic              frame_end_s;
  logic              step_edge_s;
  logic              auto_wrap_s;
  logic [CW-1:0]     next_ch_s;
  logic [31:0]       ch_word_s;
  logic [3:0]        nibble_s;
  logic [6:0]        lit_seg_s;
  logic [DIGITS-1:0] dig_onehot_s;
`ifdef SEG_LZB_EN
  logic              upper_zero_s;
`endif

  // Scan/channel control decode
  always_comb begin
    scan_tick_s  = (div_cnt_r == LAST_DIV);
    frame_end_s  = (dig_idx_r == LAST_DIG);
    step_edge_s  = step & ~step_q_r;
    auto_wrap_s  = (auto_cnt_r == LAST_AUTO);
    next_ch_s    = (cur_ch_r == LAST_CH) ? {CW{1'b0}} : (cur_ch_r + CW'(1));
    ch_word_s    = ch_data[{cur_ch_r, 5'b00000} +: 32];
    dig_onehot_s = DIGITS'(1) << dig_idx_r;
  end

  // Segment pattern for the digit lit on the next scan tick
  always_comb begin
    nibble_s = snap_r[{dig_idx_r, 2'b00} +: 4];
`ifdef SEG_LZB_EN
    upper_zero_s = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      upper_zero_s = upper_zero_s &
                     ~((j >= int'(dig_idx_r)) && (snap_r[4*j +: 4] != 4'h0));
    end
    if ((dig_idx_r != DW'(0)) && upper_zero_s) begin
      lit_seg_s = 7'h7F;
    end else begin
      lit_seg_s = seg_decode(nibble_s);
    end
`else
    lit_seg_s = seg_decode(nibble_s);
`endif
  end

  // Digit scan, frame snapshot and registered display outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_cnt_r <= {DIV_W{1'b0}};
      dig_idx_r <= {DW{1'b0}};
      snap_r    <= 32'h0000_0000;
      sel_seg_r <= {DIGITS{1'b1}};
      seg7_r    <= 7'h7F;
    end else if (scan_tick_s) begin
      div_cnt_r <= {DIV_W{1'b0}};
      sel_seg_r <= ~dig_onehot_s;
      seg7_r    <= lit_seg_s;
      if (frame_end_s) begin
        dig_idx_r <= {DW{1'b0}};
        snap_r    <= ch_word_s;
      end else begin
        dig_idx_r <= dig_idx_r + DW'(1);
      end
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Channel selection: manual follow with clamp, or auto-cycle with step override
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cur_ch_r   <= {CW{1'b0}};
      auto_cnt_r <= {AUTO_W{1'b0}};
      step_q_r   <= 1'b0;
    end else begin
      step_q_r <= step;
      if (!auto_en) begin
        auto_cnt_r <= {AUTO_W{1'b0}};
        if (int'(sel) >= NCH) begin
          cur_ch_r <= LAST_CH;
        end else begin
          cur_ch_r <= sel;
        end
      end else if (step_edge_s || auto_wrap_s) begin
        // a coincident step edge and timer wrap still advance only once
        auto_cnt_r <= {AUTO_W{1'b0}};
        cur_ch_r   <= next_ch_s;
      end else begin
        auto_cnt_r <= auto_cnt_r + AUTO_W'(1);
      end
    end
  end

  assign sel_seg = sel_seg_r;
  assign seg7    = seg7_r;
  assign cur_ch  = cur_ch_r;

endmodule

// File: tb/tb_seg_scan_monitor.sv
// Self-checking bench for seg_scan_monitor: frame-level behavioural model checked
// every cycle, plus directed literal expectations from hand-worked timelines.
module tb_seg_scan_monitor;

  localparam int NCH        = 4;
  localparam int DIGITS     = 8;
  localparam int SCAN_DIV   = 4;
  localparam int AUTO_TICKS = 20;

  logic           clk;
  logic           resetn;
  logic [127:0]   ch_data;
  logic [1:0]     sel;
  logic           auto_en;
  logic           step;
  logic [7:0]     sel_seg;
  logic [6:0]     seg7;
  logic [1:0]     cur_ch;

  logic [159:0]   ch_data5;
  logic [2:0]     sel5;
  logic [7:0]     sel_seg5;
  logic [6:0]     seg7_5;
  logic [2:0]     cur_ch5;

  int errors = 0;
  int checks = 0;

  seg_scan_monitor #(
    .NCH(NCH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .AUTO_TICKS(AUTO_TICKS)
  ) u_dut (
    .clk(clk), .resetn(resetn), .ch_data(ch_data), .sel(sel),
    .auto_en(auto_en), .step(step), .sel_seg(sel_seg), .seg7(seg7), .cur_ch(cur_ch)
  );

  seg_scan_monitor #(
    .NCH(5), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .AUTO_TICKS(AUTO_TICKS)
  ) u_dut5 (
    .clk(clk), .resetn(resetn), .ch_data(ch_data5), .sel(sel5),
    .auto_en(1'b0), .step(1'b0), .sel_seg(sel_seg5), .seg7(seg7_5), .cur_ch(cur_ch5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int          n_m;       // clock edges since reset release
  int          start_m;   // edge of last channel advance (or last manual cycle)
  int          cur_m;
  bit          step_m;
  int unsigned frames[$]; // frames[k] = value shown in frame k+1

  function automatic logic [6:0] model_seg(input int unsigned val, input int d);
    longint unsigned upper;
    upper = longint'(val) >> (4 * d);
`ifdef SEG_LZB_EN
    if (d > 0 && upper == 0) return 7'h7F;
`endif
    return hex_tab[upper & 64'hF];
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      n_m = 0; start_m = 0; cur_m = 0; step_m = 1'b0;
      frames.delete();
    end else begin
      n_m++;
      if ((n_m % SCAN_DIV) == 0 && ((n_m / SCAN_DIV) % DIGITS) == 0)
        frames.push_back(ch_data[32*cur_m +: 32]);
      if (!auto_en) begin
        cur_m   = (int'(sel) >= NCH) ? NCH - 1 : int'(sel);
        start_m = n_m;
      end else if ((step && !step_m) || (n_m - start_m) == AUTO_TICKS) begin
        cur_m   = (cur_m + 1) % NCH;
        start_m = n_m;
      end
      step_m = step;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    int ticks, d, f;
    int unsigned val;
    logic [7:0] exp_sel;
    logic [6:0] exp_seg;
    ticks = n_m / SCAN_DIV;
    if (ticks == 0) begin
      exp_sel = 8'hFF;
      exp_seg = 7'h7F;
    end else begin
      d = (ticks - 1) % DIGITS;
      f = (ticks - 1) / DIGITS;
      val = (f == 0) ? 32'h0 : frames[f-1];
      exp_sel = ~(8'h01 << d);
      exp_seg = model_seg(val, d);
    end
    check("model_sel_seg", {24'h0, sel_seg}, {24'h0, exp_sel});
    check("model_seg7", {25'h0, seg7}, {25'h0, exp_seg});
    check("model_cur_ch", {30'h0, cur_ch}, cur_m);
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_n(input int k);
    int guard;
    guard = 0;
    while (n_m != k && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (n_m != k) begin
      errors++;
      $display("FAIL wait_n: got edge %0d, expected %0d", n_m, k);
    end
  endtask

  logic [6:0] man_exp [8] = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
  logic [6:0] lzb_blank;

  initial begin
`ifdef SEG_LZB_EN
    lzb_blank = 7'h7F;
`else
    lzb_blank = 7'h40;
`endif
    resetn  = 1'b0;
    auto_en = 1'b0;
    step    = 1'b0;
    sel     = 2'd1;
    sel5    = 3'd7;
    ch_data5 = 160'h0;
    ch_data = 128'h0;
    ch_data[32 +: 32] = 32'h1234_ABCD;
    ch_data[64 +: 32] = 32'h5555_0002;
    ch_data[96 +: 32] = 32'h0000_0003;

    repeat (3) @(negedge clk);
    check("rst_sel_seg", {24'h0, sel_seg}, 32'hFF);
    check("rst_seg7", {25'h0, seg7}, 32'h7F);
    check("rst_cur_ch", {30'h0, cur_ch}, 32'h0);
    resetn = 1'b1;

    wait_n(3);
    check("pre_first_sel_seg", {24'h0, sel_seg}, 32'hFF);
    check("pre_first_seg7", {25'h0, seg7}, 32'h7F);
    wait_n(4);
    check("first_sel_seg", {24'h0, sel_seg}, 32'hFE);
    check("first_seg7", {25'h0, seg7}, 32'h40);
    check("manual_cur_ch", {30'h0, cur_ch}, 32'h1);
    check("clamp_cur_ch5", {29'h0, cur_ch5}, 32'h4);
    check("first_sel_seg5", {24'h0, sel_seg5}, 32'hFE);
    check("first_seg7_5", {25'h0, seg7_5}, 32'h40);

    // manual display of channel 1 in frame 1
    for (int d = 0; d < 8; d++) begin
      wait_n(4 * (9 + d));
      check("manual_seg7", {25'h0, seg7}, {25'h0, man_exp[d]});
      check("manual_sel_seg", {24'h0, sel_seg}, {24'h0, ~(8'h01 << d)});
    end

    // coherency: change value while digit 3 of frame 2 is lit
    wait_n(81);
    ch_data[32 +: 32] = 32'hFFFF_FFFF;
    wait_n(84);
    check("coh_digit4", {25'h0, seg7}, 32'h19);
    wait_n(96);
    check("coh_digit7", {25'h0, seg7}, 32'h79);
    check("coh_digit7_an", {24'h0, sel_seg}, 32'h7F);
    wait_n(100);
    check("coh_new_digit0", {25'h0, seg7}, 32'h0E);
    sel = 2'd0;

    // auto cycling and step
    wait_n(101);
    check("auto_start_ch", {30'h0, cur_ch}, 32'h0);
    auto_en = 1'b1;
    wait_n(120);
    check("auto_before_wrap", {30'h0, cur_ch}, 32'h0);
    wait_n(121);
    check("auto_wrap_0to1", {30'h0, cur_ch}, 32'h1);
    wait_n(130);
    step = 1'b1;
    wait_n(131);
    check("step_adv", {30'h0, cur_ch}, 32'h2);
    wait_n(150);
    check("step_held_no_adv", {30'h0, cur_ch}, 32'h2);
    wait_n(151);
    check("auto_after_step", {30'h0, cur_ch}, 32'h3);
    wait_n(171);
    check("auto_wrap_last", {30'h0, cur_ch}, 32'h0);
    wait_n(175);
    step = 1'b0;
    wait_n(177);
    step = 1'b1;
    wait_n(178);
    check("step_adv2", {30'h0, cur_ch}, 32'h1);
    wait_n(180);
    step = 1'b0;
    wait_n(197);
    step = 1'b1;
    wait_n(198);
    check("step_and_wrap_once", {30'h0, cur_ch}, 32'h2);
    wait_n(200);
    auto_en = 1'b0;
    step = 1'b0;
    sel = 2'd3;
    wait_n(201);
    check("back_to_manual", {30'h0, cur_ch}, 32'h3);

    // mid-frame reset, then leading-zero pattern on channel 3
    wait_n(210);
    ch_data[96 +: 32] = 32'h0000_00A0;
    sel5 = 3'd2;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_sel_seg", {24'h0, sel_seg}, 32'hFF);
    check("midrst_seg7", {25'h0, seg7}, 32'h7F);
    check("midrst_cur_ch", {30'h0, cur_ch}, 32'h0);
    resetn = 1'b1;
    wait_n(4);
    check("sel5_in_range", {29'h0, cur_ch5}, 32'h2);
    wait_n(36);
    check("lzb_digit0", {25'h0, seg7}, 32'h40);
    wait_n(40);
    check("lzb_digit1", {25'h0, seg7}, 32'h08);
    wait_n(44);
    check("lzb_digit2", {25'h0, seg7}, {25'h0, lzb_blank});
    wait_n(64);
    check("lzb_digit7", {25'h0, seg7}, {25'h0, lzb_blank});
    check("lzb_digit7_an", {24'h0, sel_seg}, 32'h7F);
    wait_n(70);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_monitor.md
# seg_scan_monitor

Parametrised debug display monitor for the CPU board. It takes a flattened bus of NCH 32-bit debug channels (PC, instruction, register-file taps, memory words), selects one manually or by auto-cycling, and drives a time-multiplexed common-anode seven-segment array of DIGITS digits. Each scan frame shows one coherent value, because the channel is snapshotted once per frame. It replaces the fixed 8-digit display driver and the external channel mux at the board top level.

## Interface
- NCH, 16, number of 32-bit input channels (2..32); CW = $clog2(NCH)
- DIGITS, 8, number of displayed hex digits (1..8); digit i shows nibble i, digit 0 rightmost
- SCAN_DIV, 100000, clk cycles per digit slot (>= 2)
- AUTO_TICKS, 50000000, clk cycles per channel in auto mode (>= 2)

- clk  in  1  system clock; all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- ch_data  in  NCH*32  channel c occupies bits [32c+31:32c]
- sel  in  CW  manual channel select
- auto_en  in  1  1 = auto-cycle channels, 0 = manual
- step  in  1  level input, already debounced; rising edge advances channel in auto mode
- sel_seg  out  DIGITS  digit anodes, active-low, one-hot-low
- seg7  out  7  segments {g,f,e,d,c,b,a}, active-low
- cur_ch  out  CW  channel currently being displayed

## Operation
- Reset (resetn=0 at a clk edge): div_cnt=0, dig_idx=0, auto_cnt=0, cur_ch=0, snap=0, step_q=0, sel_seg=all 1, seg7=7'h7F.
- Divider: div_cnt counts 0..SCAN_DIV-1 and wraps; the wrap cycle is scan_tick.
- On scan_tick: dig_idx advances and wraps from DIGITS-1 to 0. sel_seg drives digit dig_idx_next low and all others high. seg7 = decode(snap nibble dig_idx_next).
- Frame snapshot: on a scan_tick where dig_idx wraps to 0, snap <= ch_data[cur_ch] as sampled that cycle. snap never changes mid-frame.
- Manual mode (auto_en=0): cur_ch <= sel every cycle. If sel >= NCH, cur_ch <= NCH-1 (clamp). auto_cnt held at 0.
- Auto mode (auto_en=1):
  - auto_cnt counts 0..AUTO_TICKS-1. On wrap, cur_ch increments, wrapping NCH-1 to 0.
  - A step rising edge (step & ~step_q) increments cur_ch and clears auto_cnt in the same cycle.
  - A step edge and an auto_cnt wrap in the same cycle produce one increment only.
- Mode change 0->1: auto mode starts from the current cur_ch with auto_cnt=0. Mode change 1->0: cur_ch follows sel on the next cycle.
- Hex decode, active-low {g..a}: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.

## Timing
- All outputs are registered; nothing is combinational from input to output.
- First lit digit: digit 0, SCAN_DIV cycles after reset release. It shows snap=0 ("0"). The first real snapshot latches after DIGITS scan_ticks.
- Value latency: a change on ch_data appears at most (2*DIGITS)*SCAN_DIV cycles later, and always at a frame boundary.
- Channel switch: cur_ch updates 1 cycle after the sel change, step edge or auto wrap. Display follows at the next frame boundary.
- Reset mid-frame: everything returns to reset values at that edge. No partial-frame output.

## Configuration
- SEG_LZB_EN defined: leading-zero blanking. A digit i > 0 whose nibble and all higher displayed nibbles of snap are zero outputs seg7=7'h7F; its anode is still scanned. Digit 0 is never blanked, so value 0 shows a single "0".
- SEG_LZB_EN undefined: all DIGITS digits always show their hex nibble, including leading zeros.

## Test plan
- Use SCAN_DIV=4, AUTO_TICKS=20, NCH=4, DIGITS=8 throughout.
- Reset: hold resetn=0 for 3 cycles, then release. Required: sel_seg=8'hFF and seg7=7'h7F until cycle 4 after release. Then sel_seg=8'hFE and seg7=7'h40.
- Manual display: ch_data[1]=32'h1234ABCD, sel=1. After two frames, the digit 0..7 scan shows seg7 21,46,03,08,19,30,24,79 with one-hot-low anodes FE,FD,...,7F.
- Coherency: change ch_data[1] to 32'hFFFFFFFF while digit 3 is lit. Required: digits 3..7 still show the old nibbles; the new value appears only from the next digit 0.
- Auto and step: auto_en=1. Required: cur_ch goes 0->1 after 20 cycles. A step edge at auto_cnt=10 gives cur_ch=2 and the next advance 20 cycles later. NCH-1 wraps to 0. Step held high does not re-advance.
- Clamp and blanking: sel=4'hF with CW=2 is impossible, so instead run NCH=5 with sel=7; required cur_ch=4. With SEG_LZB_EN and snap=32'h0000_00A0, digits 2..7 give 7F, digit 1 gives 08 and digit 0 gives 40.
